// File: rtl/rle_pkg.sv
// Shared types and default sizing for the run-length stream decoder.
package rle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SKIP = 2'd2,
    DONE = 2'd3
  } rle_state_e;

  localparam int RLE_RUN_W    = 10;
  localparam int RLE_MAX_RUNS = 8;

endpackage

// File: rtl/rle_run_mux.sv
// Selects one run length out of the captured flat run bus; out-of-range index yields 0.
module rle_run_mux #(
  parameter int RUN_W    = 10,
  parameter int MAX_RUNS = 8,
  localparam int CNT_W   = $clog2(MAX_RUNS + 1)
) (
  input  logic [MAX_RUNS*RUN_W-1:0] runs_i,
  input  logic [CNT_W-1:0]          idx_i,
  output logic [RUN_W-1:0]          run_o
);

  always_comb begin
    run_o = '0;
    for (int i = 0; i < MAX_RUNS; i++) begin
      if (idx_i == CNT_W'(i)) run_o = runs_i[i*RUN_W +: RUN_W];
    end
  end

endmodule

// File: rtl/rle_stream_decoder.sv
// Expands a list of run lengths into an alternating binary symbol stream with
// valid/ready backpressure, end-of-frame marking and mid-frame reload.
//
// state | meaning
// IDLE  | waiting for new_im
// RUN   | presenting symbols of run idx, rem beats left (rem > 0)
// SKIP  | bubble cycle stepping over a zero-length run
// DONE  | frame complete, frame_done pulse, back to IDLE
module rle_stream_decoder
  import rle_pkg::*;
#(
  parameter int RUN_W    = RLE_RUN_W,
  parameter int MAX_RUNS = RLE_MAX_RUNS,
  localparam int CNT_W   = $clog2(MAX_RUNS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      new_im_i,
  input  logic [MAX_RUNS*RUN_W-1:0] runs_i,
  input  logic [CNT_W-1:0]          n_runs_i,
  input  logic                      first_sym_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_sym_o,
  output logic                      out_last_o,
  output logic                      frame_done_o,
  output logic                      aborted_o,
  output logic                      busy_o
);

  rle_state_e                state_q, state_d;
  logic [MAX_RUNS*RUN_W-1:0] runs_q, runs_d;
  logic [CNT_W-1:0]          n_runs_q, n_runs_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [RUN_W-1:0]          rem_q, rem_d;
  logic                      sym_q, sym_d;

  logic out_valid_q, out_valid_d;
  logic out_sym_q, out_sym_d;
  logic out_last_q, out_last_d;
  logic frame_done_q, frame_done_d;
  logic aborted_q, aborted_d;
  logic busy_q, busy_d;

  logic [CNT_W-1:0] n_clamped;
  logic [CNT_W-1:0] idx_nxt;
  logic [RUN_W-1:0] run_first;
  logic [RUN_W-1:0] run_next;
  logic             last_run;
  logic             accept;

  assign n_clamped = (n_runs_i > CNT_W'(MAX_RUNS)) ? CNT_W'(MAX_RUNS) : n_runs_i;
  assign run_first = runs_i[RUN_W-1:0];
  assign idx_nxt   = idx_q + CNT_W'(1);
  assign last_run  = (idx_q == n_runs_q - CNT_W'(1));
  assign accept    = out_valid_q && out_ready_i;

  rle_run_mux #(
    .RUN_W    (RUN_W),
    .MAX_RUNS (MAX_RUNS)
  ) u_run_mux (
    .runs_i (runs_q),
    .idx_i  (idx_nxt),
    .run_o  (run_next)
  );

  always_comb begin
    state_d   = state_q;
    runs_d    = runs_q;
    n_runs_d  = n_runs_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    sym_d     = sym_q;
    aborted_d = 1'b0;

    if (new_im_i) begin
      aborted_d = (state_q == RUN) || (state_q == SKIP);
      runs_d    = runs_i;
      n_runs_d  = n_clamped;
      idx_d     = '0;
      rem_d     = run_first;
      sym_d     = first_sym_i;
      if (n_clamped == '0)         state_d = DONE;
      else if (run_first == '0)    state_d = SKIP;
      else                         state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (rem_q > RUN_W'(1)) begin
              rem_d = rem_q - RUN_W'(1);
            end else if (!last_run) begin
              idx_d   = idx_nxt;
              sym_d   = ~sym_q;
              rem_d   = run_next;
              state_d = (run_next == '0) ? SKIP : RUN;
            end else begin
              state_d = DONE;
            end
          end
        end
        SKIP: begin
          if (last_run) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_nxt;
            sym_d   = ~sym_q;
            rem_d   = run_next;
            state_d = (run_next == '0) ? SKIP : RUN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    out_valid_d  = (state_d == RUN);
    out_sym_d    = (state_d == RUN) ? sym_d : 1'b0;
    out_last_d   = (state_d == RUN) && (rem_d == RUN_W'(1)) &&
                   (idx_d == n_runs_d - CNT_W'(1));
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d == RUN) || (state_d == SKIP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      runs_q       <= '0;
      n_runs_q     <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      sym_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sym_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      runs_q       <= runs_d;
      n_runs_q     <= n_runs_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      sym_q        <= sym_d;
      out_valid_q  <= out_valid_d;
      out_sym_q    <= out_sym_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_sym_o    = out_sym_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = frame_done_q;
  assign aborted_o    = aborted_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/rle_stream_decoder.md
# rle_stream_decoder

Parametrised run-length decoder for the vision pipeline: expands a frame's list of up to MAX_RUNS run lengths into a one-symbol-per-beat stream of alternating binary symbols, feeding the VGA pixel FIFO. Successor to the fixed three-run decoder. Adds a run-count input, a selectable start symbol, zero-length run skipping, valid/ready backpressure from the FIFO, end-of-frame marking, and mid-frame abort/reload.

## Interface
Parameters:
- RUN_W, 10, width of one run length (max run 2^RUN_W-1 pixels)
- MAX_RUNS, 8, number of run slots in the flattened input bus
- CNT_W, $clog2(MAX_RUNS+1), width of n_runs (derived, not overridden)

Ports:
- CLK  in  1  sole clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- new_im  in  1  frame load strobe; samples runs/n_runs/first_sym
- runs  in  MAX_RUNS*RUN_W  run i at bits [i*RUN_W +: RUN_W], run 0 emitted first
- n_runs  in  CNT_W  number of valid runs; values above MAX_RUNS clamp to MAX_RUNS
- first_sym  in  1  symbol of run 0
- out_valid  out  1  out_sym is valid
- out_ready  in  1  FIFO can accept (not full)
- out_sym  out  1  current pixel symbol
- out_last  out  1  marks final beat of the frame
- frame_done  out  1  one-cycle pulse after the last beat is accepted, or on an empty frame
- aborted  out  1  one-cycle pulse when new_im interrupts a frame in progress
- busy  out  1  high from capture until the frame completes

## Operation
- States: IDLE, RUN, SKIP, DONE.
- IDLE:
  - new_im captures runs, clamped n_runs and first_sym into registers.
  - Sets idx=0, rem=run[0], sym=first_sym.
  - Goes to RUN, or to DONE if clamped n_runs==0.
- RUN with rem==0 (zero-length run):
  - Goes to SKIP for exactly one cycle.
  - out_valid=0 in SKIP.
  - Toggles sym and advances idx. Reloads rem from run[idx+1], or goes to DONE if idx was the last run.
- RUN with rem>0:
  - out_valid=1, out_sym=sym.
  - out_last=1 when rem==1 and idx==n_runs-1 and every later run is absent.
  - On accept (out_valid&&out_ready):
    - If rem>1: rem decrements.
    - If rem==1 and more runs remain: idx advances, sym toggles, rem reloads. The next beat follows in the next cycle with no bubble, unless the next run is zero-length.
    - Otherwise (final beat): goes to DONE.
- out_ready=0 in RUN: out_sym, out_last and rem hold; no state change.
- DONE: frame_done=1 for one cycle, busy drops, returns to IDLE.
- new_im in RUN/SKIP/DONE:
  - Discards the current frame and reloads as from IDLE.
  - aborted pulses, unless the state was DONE.
  - new_im has priority over a simultaneous accept. That beat counts as not transferred; the FIFO must ignore it because its sample equals the reload.
- Zero-length run as the last run: the frame ends without out_last. frame_done still pulses.
- Arithmetic: rem is RUN_W bits unsigned, never wraps (decrements only when >0). idx is CNT_W bits.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out_sym=0, out_last=0, frame_done=0, aborted=0, busy=0.
  - All capture registers are 0.
- Load latency: new_im high at edge k gives out_valid=1 and busy=1 from cycle k+1.
- Throughput: one beat per cycle while out_ready=1. Each zero-length run adds one bubble cycle.
- Frame of total length P with no zero runs and out_ready held high:
  - Beats occupy cycles k+1..k+P.
  - frame_done pulses at k+P+1.
  - A new new_im is accepted at k+P+1.
- Stability: once out_valid=1, out_sym/out_last stay constant until accepted. The only exceptions are new_im and reset.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously).

## Structure
- Package rle_pkg: state enum (IDLE, RUN, SKIP, DONE) and default RUN_W/MAX_RUNS constants.
- Sub-module rle_run_mux: combinational selection of run[idx] from the captured flat bus, parametrised by RUN_W and MAX_RUNS.
- The FSM, counters and handshake stay in rle_stream_decoder.

## Test plan
- Runs {3,2,4}, n_runs=3, first_sym=0, ready=1 -> out_sym 000 11 0000; out_last on beat 9; frame_done at cycle k+10.
- Same frame, ready toggled 1/0 every cycle -> identical 9-symbol sequence; outputs held during ready=0; no beat lost or duplicated.
- Runs {2,0,3}, first_sym=1 -> 11 then one bubble, then 111 (double toggle); 5 beats total.
- n_runs=0 -> no out_valid, frame_done pulses at k+1. n_runs=MAX_RUNS+3 behaves as MAX_RUNS.
- new_im asserted on beat 4 of a 10-beat frame with new runs {1,1} -> aborted pulses; next beats are first_sym, ~first_sym, then frame_done.
- RST_N low mid-run with out_valid=1 -> all outputs 0 immediately; after release, IDLE until new_im.
